// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with double-buffered code/dot registers.
// Optional leading-zero blanking is compiled in when SEG_LZB_EN is defined.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        wr_addr,
  input  logic [31:0] wr_data,
  input  logic        disp_en,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [31:0] CODE_RST = 32'hBBBB_BBBB;

  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   sh_code_q, sh_code_d;
  logic [7:0]    sh_dot_q, sh_dot_d;
  logic [31:0]   act_code_q, act_code_d;
  logic [7:0]    act_dot_q, act_dot_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          fd_q, fd_d;

  logic          tick;
  logic          commit;
  logic [3:0]    nib;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      4'd10:   s = 7'b0111111;
      4'd11:   s = 7'b1111111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  assign tick   = (pre_q == PRE_LAST);
  assign commit = tick && (idx_q == 3'd7);
  assign nib    = act_code_q[{idx_q, 2'b00} +: 4];

`ifdef SEG_LZB_EN
  logic lz_dark;
  assign lz_dark = (idx_q != 3'd0) && ((act_code_q >> {idx_q, 2'b00}) == 32'd0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q      <= '0;
      idx_q      <= '0;
      sh_code_q  <= CODE_RST;
      sh_dot_q   <= '0;
      act_code_q <= CODE_RST;
      act_dot_q  <= '0;
      an_q       <= '1;
      seg_q      <= '1;
      fd_q       <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      sh_code_q  <= sh_code_d;
      sh_dot_q   <= sh_dot_d;
      act_code_q <= act_code_d;
      act_dot_q  <= act_dot_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      fd_q       <= fd_d;
    end
  end

  // Commit reads the post-write shadow value so a write on the frame boundary lands this frame.
  always_comb begin
    pre_d      = tick ? '0 : pre_q + PW'(1);
    idx_d      = tick ? idx_q + 3'd1 : idx_q;
    sh_code_d  = (wr_en && !wr_addr) ? wr_data : sh_code_q;
    sh_dot_d   = (wr_en && wr_addr) ? wr_data[7:0] : sh_dot_q;
    act_code_d = commit ? sh_code_d : act_code_q;
    act_dot_d  = commit ? sh_dot_d : act_dot_q;
    fd_d       = commit;
  end

  always_comb begin
    an_d = '1;
    if (disp_en) an_d = ~(8'd1 << idx_q);
`ifdef SEG_LZB_EN
    if (lz_dark) an_d = '1;
`endif
    seg_d = {(nib == 4'd11) ? 1'b1 : ~act_dot_q[idx_q], decode(nib)};
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboarded bench for seg_scan_ctrl (SCAN_DIV = 4) against a cycle-count reference model.
module tb_seg_scan_ctrl;

  localparam int unsigned DIV = 4;
  localparam logic [6:0] SEGTAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b1111111,
    7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
    logic       fd;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, wr_en, wr_addr, disp_en;
  logic [31:0] wr_data;
  logic [7:0]  an, seg;
  logic        frame_done;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_no  = 0;

  int          m_e;
  logic [31:0] m_sh_code, m_act_code;
  logic [7:0]  m_sh_dot, m_act_dot;
  logic        den_cur;

  seg_scan_ctrl #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .disp_en(disp_en), .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and predict outputs after the coming rising edge.
  task automatic cyc(input logic r, input logic we, input logic a,
                     input logic [31:0] d, input logic den);
    exp_t x;
    int dg;
    logic [3:0] nb;
    @(negedge clk);
    rst = r; wr_en = we; wr_addr = a; wr_data = d; disp_en = den;
    cyc_no++;
    x.cyc = cyc_no;
    if (r) begin
      x.an = 8'hFF; x.seg = 8'hFF; x.fd = 1'b0;
      m_e = 0;
      m_sh_code = 32'hBBBB_BBBB; m_act_code = 32'hBBBB_BBBB;
      m_sh_dot = 8'h00; m_act_dot = 8'h00;
    end else begin
      dg = (m_e / DIV) % 8;
      nb = 4'((m_act_code >> (4 * dg)) & 32'hF);
      x.an = den ? ~(8'd1 << dg) : 8'hFF;
`ifdef SEG_LZB_EN
      if (dg > 0 && (m_act_code >> (4 * dg)) == 32'd0) x.an = 8'hFF;
`endif
      x.seg = {(nb == 4'd11) ? 1'b1 : ~m_act_dot[dg], SEGTAB[nb]};
      x.fd = (m_e % (8 * DIV)) == (8 * DIV - 1);
      if (we && !a) m_sh_code = d;
      if (we && a)  m_sh_dot = d[7:0];
      if (x.fd) begin
        m_act_code = m_sh_code;
        m_act_dot  = m_sh_dot;
      end
      m_e++;
    end
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, den_cur);
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d, den_cur);
  endtask

  task automatic to_boundary;
    while (m_e % (8 * DIV) != 8 * DIV - 1) idle(1);
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_tests++;
      if (an !== x.an || seg !== x.seg || frame_done !== x.fd) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d an=%h/%h seg=%b/%b frame_done=%b/%b (got/expected)",
                 x.cyc, an, x.an, seg, x.seg, frame_done, x.fd);
      end
    end
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = 1'b0; wr_data = '0; disp_en = 1'b1;
    den_cur = 1'b1;
    m_e = 0;
    m_sh_code = 32'hBBBB_BBBB; m_act_code = 32'hBBBB_BBBB;
    m_sh_dot = 8'h00; m_act_dot = 8'h00;

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(40);
    wr(1'b0, 32'h1234_5678);
    idle(60);
    to_boundary();
    wr(1'b0, 32'h0000_0009);
    idle(40);
    wr(1'b1, 32'hFFFF_FF02);
    wr(1'b0, 32'hBBBB_BBA1);
    idle(70);
    den_cur = 1'b0;
    idle(70);
    den_cur = 1'b1;
    wr(1'b0, 32'h0000_0042);
    idle(70);
    idle(13);
    cyc(1'b1, 1'b1, 1'b0, 32'h7777_7777, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(40);

    for (int i = 0; i < 1500; i++) begin
      logic we, a, r;
      logic [31:0] d;
      r  = ($urandom_range(0, 299) == 0);
      we = ($urandom_range(0, 7) == 0);
      a  = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
      if ($urandom_range(0, 49) == 0) den_cur = ~den_cur;
      cyc(r, we, a, d, den_cur);
    end
    den_cur = 1'b1;
    to_boundary();
    wr(1'b0, 32'h0000_0010);
    idle(40);

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
